// File: rtl/signal_composer_ramp_pkg.sv
// Shared types and helpers for the signal composer: envelope state encoding,
// pipeline width/latency constants and the two's-complement saturator.
package signal_composer_pkg;

    typedef enum logic [1:0] {
        RAMP_OFF  = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } rampState_t;

    localparam int DEF_NUM_WAVES = 4;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_RAMP_BITS = 8;

    function automatic int treeLevels(input int numWaves);
        return $clog2(numWaves);
    endfunction

    // One guard bit beyond the exact growth so the offset stage never overflows.
    function automatic int sumWidth(input int width, input int numWaves);
        return width + $clog2(numWaves) + 1;
    endfunction

    // Input register, adder tree levels, offset/saturate stage, scale stage.
    function automatic int pipeLatency(input int numWaves);
        return treeLevels(numWaves) + 3;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (width - 1));
        if (value > maxV) begin
            return maxV;
        end else if (value < minV) begin
            return minV;
        end
        return value;
    endfunction

endpackage

// File: rtl/signal_composer_ramp_if.sv
// Sample, offset and envelope-control bundle between the composer and its
// producer; master drives samples/controls, slave returns the composed output.
interface signal_composer_ramp_if
    import signal_composer_pkg::*;
#(
    parameter int NUM_WAVES = DEF_NUM_WAVES,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RAMP_BITS = DEF_RAMP_BITS
);
    logic [NUM_WAVES*WIDTH-1:0] wave;
    logic [NUM_WAVES-1:0]       wave_valid;
    logic [NUM_WAVES-1:0]       ch_enable;
    logic signed [WIDTH-1:0]    offset;
    logic signed [WIDTH-1:0]    seq;
    logic                       dyn_offset_disable;
    logic                       enable_dac;
    logic [RAMP_BITS-1:0]       ramp_step;
    logic signed [WIDTH-1:0]    signal_out;
    logic                       signal_valid;
    rampState_t                 ramp_state;
    logic                       ramp_done;

    modport master (
        output wave, wave_valid, ch_enable, offset, seq, dyn_offset_disable,
               enable_dac, ramp_step,
        input  signal_out, signal_valid, ramp_state, ramp_done
    );

    modport slave (
        input  wave, wave_valid, ch_enable, offset, seq, dyn_offset_disable,
               enable_dac, ramp_step,
        output signal_out, signal_valid, ramp_state, ramp_done
    );
endinterface

// File: rtl/signal_composer_ramp_envelope.sv
// Gain envelope: ramps the gain towards unity or zero by ramp_step per clock,
// clamping at the ends and pulsing done when a ramp settles.
module ramp_envelope
    import signal_composer_pkg::*;
#(
    parameter int RAMP_BITS = DEF_RAMP_BITS
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 enable_dac_i,
    input  logic [RAMP_BITS-1:0] ramp_step_i,
    output logic [RAMP_BITS:0]   gain_o,
    output rampState_t           state_o,
    output logic                 done_o
);
    localparam logic [RAMP_BITS+1:0] UNITY = (RAMP_BITS + 2)'(1) << RAMP_BITS;

    rampState_t           state_q, state_d;
    logic [RAMP_BITS:0]   gain_q, gain_d;
    logic                 done_q, done_d;
    logic [RAMP_BITS+1:0] gainExt;
    logic [RAMP_BITS+1:0] stepExt;
    logic [RAMP_BITS+1:0] gainUp;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= RAMP_OFF;
            gain_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            done_q  <= done_d;
        end
    end

    // The request level alone picks the direction, so a reversal mid-ramp simply
    // continues from the current gain; done fires only when a settled end is entered.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        done_d  = 1'b0;
        gainExt = {1'b0, gain_q};
        stepExt = {2'b00, ramp_step_i};
        gainUp  = gainExt + stepExt;
        if (enable_dac_i) begin
            if ((ramp_step_i == '0) || (gainUp >= UNITY)) begin
                gain_d  = UNITY[RAMP_BITS:0];
                state_d = RAMP_ON;
                done_d  = (state_q != RAMP_ON);
            end else begin
                gain_d  = gainUp[RAMP_BITS:0];
                state_d = RAMP_UP;
            end
        end else begin
            if ((ramp_step_i == '0) || (stepExt >= gainExt)) begin
                gain_d  = '0;
                state_d = RAMP_OFF;
                done_d  = (state_q != RAMP_OFF);
            end else begin
                gain_d  = gain_q - stepExt[RAMP_BITS:0];
                state_d = RAMP_DOWN;
            end
        end
    end

    assign gain_o  = gain_q;
    assign state_o = state_q;
    assign done_o  = done_q;
endmodule

// File: rtl/signal_composer_ramp.sv
// Sums enabled waveform channels through a registered adder tree, adds the
// static/dynamic offset with saturation, then scales by the ramp envelope gain.
module signal_composer_ramp
    import signal_composer_pkg::*;
#(
    parameter int NUM_WAVES = DEF_NUM_WAVES,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RAMP_BITS = DEF_RAMP_BITS
) (
    input logic                    clk,
    input logic                    aresetn,
    signal_composer_ramp_if.slave  bus
);
    localparam int SUM_W  = sumWidth(WIDTH, NUM_WAVES);
    localparam int OFS_W  = SUM_W + 1;
    localparam int LAT    = pipeLatency(NUM_WAVES);
    localparam int PROD_W = WIDTH + RAMP_BITS + 2;

    // Heap-ordered tree: leaves at NUM_WAVES..2*NUM_WAVES-1, root at index 1.
    logic signed [SUM_W-1:0]  node_q [1:2*NUM_WAVES-1];
    logic [LAT-1:0]           vld_q;
    logic signed [WIDTH-1:0]  sat_q, sat_d;
    logic signed [WIDTH-1:0]  out_q, out_d;
    logic signed [WIDTH-1:0]  seqTerm;
    logic signed [OFS_W-1:0]  ofsSum;
    logic signed [PROD_W-1:0] product;
    logic [RAMP_BITS:0]       gain;
    rampState_t               rampState;
    logic                     rampDone;
    logic                     validIn;

    ramp_envelope #(.RAMP_BITS(RAMP_BITS)) u_env (
        .clk          (clk),
        .aresetn      (aresetn),
        .enable_dac_i (bus.enable_dac),
        .ramp_step_i  (bus.ramp_step),
        .gain_o       (gain),
        .state_o      (rampState),
        .done_o       (rampDone)
    );

    assign validIn = &(bus.wave_valid | ~bus.ch_enable);

    always_comb begin
        seqTerm = bus.dyn_offset_disable ? '0 : bus.seq;
        ofsSum  = OFS_W'(node_q[1]) + OFS_W'(bus.offset) + OFS_W'(seqTerm);
        sat_d   = WIDTH'(saturate(64'(ofsSum), WIDTH));
        product = PROD_W'(sat_q) * PROD_W'($signed({1'b0, gain}));
        out_d   = WIDTH'(product >>> RAMP_BITS);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 1; i < 2 * NUM_WAVES; i++) begin
                node_q[i] <= '0;
            end
            vld_q <= '0;
            sat_q <= '0;
            out_q <= '0;
        end else begin
            for (int k = 0; k < NUM_WAVES; k++) begin
                node_q[NUM_WAVES + k] <= bus.ch_enable[k]
                    ? SUM_W'($signed(bus.wave[k*WIDTH +: WIDTH])) : '0;
            end
            for (int i = 1; i < NUM_WAVES; i++) begin
                node_q[i] <= node_q[2*i] + node_q[2*i + 1];
            end
            vld_q <= {vld_q[LAT-2:0], validIn};
            sat_q <= sat_d;
            out_q <= out_d;
        end
    end

    assign bus.signal_out   = out_q;
    assign bus.signal_valid = vld_q[LAT-1];
    assign bus.ramp_state   = rampState;
    assign bus.ramp_done    = rampDone;
endmodule

// File: doc/signal_composer_ramp.md
SIGNAL_COMPOSER_RAMP -- requirements
Module: signal_composer_ramp

Interface
REQ-001 SHALL have parameter NUM_WAVES, default 4, number of summed waveform channels (power of two, 2..8).
REQ-002 SHALL have parameter WIDTH, default 16, signed sample width of inputs and output.
REQ-003 SHALL have parameter RAMP_BITS, default 8, fractional bits of ramp gain; unity gain = 2^RAMP_BITS.
REQ-004 SHALL have port clk  input  1  sample clock; single clock domain.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wave  input  NUM_WAVES*WIDTH  packed signed samples; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port wave_valid  input  NUM_WAVES  per-channel valid.
REQ-008 SHALL have port ch_enable  input  NUM_WAVES  per-channel enable.
REQ-009 SHALL have port offset  input  WIDTH  signed static offset.
REQ-010 SHALL have port seq  input  WIDTH  signed dynamic (sequence) offset.
REQ-011 SHALL have port dyn_offset_disable  input  1  1 = ignore seq.
REQ-012 SHALL have port enable_dac  input  1  level request; 1 = ramp up to unity, 0 = ramp down to zero.
REQ-013 SHALL have port ramp_step  input  RAMP_BITS  gain increment per clk; 0 = step change.
REQ-014 SHALL have port signal_out  output  WIDTH  signed composed sample.
REQ-015 SHALL have port signal_valid  output  1  valid aligned with signal_out.
REQ-016 SHALL have port ramp_state  output  2  current envelope state (OFF=0, UP=1, ON=2, DOWN=3).
REQ-017 SHALL have port ramp_done  output  1  one-clk pulse on entering ON or OFF from UP/DOWN.

Function
REQ-018 Disabled channel SHALL contribute 0 to the sum and SHALL be treated as valid.
REQ-019 Channel sum SHALL use a registered, full-precision adder tree of clog2(NUM_WAVES) stages, width WIDTH+clog2(NUM_WAVES)+1; no intermediate saturation.
REQ-020 Offset stage SHALL add offset plus seq (seq forced to 0 when dyn_offset_disable=1) at full precision, then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 Scale stage SHALL compute (saturated sum * gain) arithmetic-shifted right by RAMP_BITS (floor), gain in 0..2^RAMP_BITS, using gain value present in the cycle the sample enters the stage.
REQ-022 Total latency wave->signal_out SHALL be L = clog2(NUM_WAVES)+3 clk; signal_valid SHALL be AND of enabled-channel valids delayed L clk (1 if no channel enabled).
REQ-023 Envelope FSM: OFF (gain 0) -> UP when enable_dac=1; UP: gain += ramp_step per clk, clamp at unity -> ON; ON -> DOWN when enable_dac=0; DOWN: gain -= ramp_step per clk, clamp at 0 -> OFF.
REQ-024 UP with enable_dac=0 SHALL go to DOWN from current gain; DOWN with enable_dac=1 SHALL go to UP from current gain; no ramp_done on reversal.
REQ-025 ramp_step=0 SHALL set gain to target (unity or 0) in one clk and enter ON/OFF with ramp_done.
REQ-026 Gain arithmetic SHALL never wrap; overshoot past unity or below 0 SHALL clamp.

Reset
REQ-027 aresetn low SHALL immediately clear all pipeline registers, signal_out=0, signal_valid=0, gain=0, ramp_state=OFF, ramp_done=0, regardless of clk.
REQ-028 After release, first valid output SHALL appear no earlier than L clk after first valid input; envelope SHALL restart from OFF.

Structure
REQ-029 Package signal_composer_pkg SHALL hold ramp state encoding, clog2-derived width constants and the saturate function.
REQ-030 Envelope FSM and gain register SHALL be sub-module ramp_envelope; adder tree and scaling remain in top level.

Verification (NUM_WAVES=4, WIDTH=16, RAMP_BITS=8, L=5)
REQ-031 waves 1000/2000/3000/4000, all enabled/valid, offset 100, seq 50, ramp_step 0, enable_dac 1 -> after L clk signal_out=10150, valid=1; dyn_offset_disable=1 -> 10100.
REQ-032 all waves 30000 -> 32767; all waves -30000, offset -1000 -> -32768.
REQ-033 constant sum 1000, ramp_step 64, enable_dac rises -> gains 64,128,192,256 on successive clk, outputs 250,500,750,1000, ramp_done single pulse entering ON.
REQ-034 enable_dac falls at gain 128 during UP -> gain 64, 0, state OFF, ramp_done pulse; no pulse at reversal.
REQ-035 ch_enable=0101, wave_valid[1]=0, waves 10/20/30/40 -> signal_out=40, signal_valid=1.
REQ-036 aresetn low mid-ramp between clk edges -> outputs 0, ramp_state OFF before next edge.
